// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Multi-cycle adder/subtractor. Processes one DIGIT-bit slice
//               per clock, LSB slice first, with the inter-slice carry held
//               in a flop. start/busy/done handshake; returns sum, carry-out
//               and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_x,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_s,
    output logic             o_c,
    output logic             o_v
);

    localparam int c_N  = WIDTH / DIGIT;
    localparam int c_CW = (c_N > 1) ? $clog2(c_N) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // The slice loop only covers the operand exactly when DIGIT divides WIDTH
    generate
        if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("serial_adder: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    logic [1:0]       r_state_q, w_state_d;
    logic [WIDTH-1:0] r_a_q,     w_a_d;
    logic [WIDTH-1:0] r_b_q,     w_b_d;
    logic             r_cy_q,    w_cy_d;
    logic [WIDTH-1:0] r_res_q,   w_res_d;
    logic [c_CW-1:0]  r_cnt_q,   w_cnt_d;
    logic [WIDTH-1:0] r_s_q,     w_s_d;
    logic             r_c_q,     w_c_d;
    logic             r_v_q,     w_v_d;

    logic             w_accept;
    logic             w_last;
    int               w_base;
    logic [DIGIT-1:0] w_a_k;
    logic [DIGIT-1:0] w_b_k;
    logic [DIGIT:0]   w_slice;
    logic             w_cin_msb;

    assign w_accept = i_start && (r_state_q != c_RUN);
    assign w_last   = (r_cnt_q == c_CW'(c_N - 1));

    // Current slice sum; carry into the top bit recovered from the sum bit
    always_comb begin
        w_base    = int'(r_cnt_q) * DIGIT;
        w_a_k     = r_a_q[w_base +: DIGIT];
        w_b_k     = r_b_q[w_base +: DIGIT];
        w_slice   = {1'b0, w_a_k} + {1'b0, w_b_k} + {{DIGIT{1'b0}}, r_cy_q};
        w_cin_msb = w_a_k[DIGIT-1] ^ w_b_k[DIGIT-1] ^ w_slice[DIGIT-1];
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q <= c_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_IDLE:  w_state_d = w_accept ? c_RUN : c_IDLE;
            c_RUN:   w_state_d = w_last ? c_DONE : c_RUN;
            c_DONE:  w_state_d = w_accept ? c_RUN : c_IDLE;
            default: w_state_d = c_IDLE;
        endcase
    end

    // Output decode from state
    always_comb begin
        o_busy = (r_state_q == c_RUN);
        o_done = (r_state_q == c_DONE);
    end

    // Datapath: operand capture on accept, one slice per RUN cycle
    always_comb begin
        w_a_d   = r_a_q;
        w_b_d   = r_b_q;
        w_cy_d  = r_cy_q;
        w_res_d = r_res_q;
        w_cnt_d = r_cnt_q;
        w_s_d   = r_s_q;
        w_c_d   = r_c_q;
        w_v_d   = r_v_q;
        if (w_accept) begin
            // Subtract as A + ~B + ~borrow
            w_a_d   = i_a;
            w_b_d   = i_sub ? ~i_b : i_b;
            w_cy_d  = i_sub ? ~i_x : i_x;
            w_cnt_d = '0;
        end else if (r_state_q == c_RUN) begin
            w_res_d[w_base +: DIGIT] = w_slice[DIGIT-1:0];
            w_cy_d                   = w_slice[DIGIT];
            if (w_last) begin
                w_cnt_d = '0;
                w_s_d   = w_res_d;
                w_c_d   = w_slice[DIGIT];
                w_v_d   = w_cin_msb ^ w_slice[DIGIT];
            end else begin
                w_cnt_d = r_cnt_q + c_CW'(1);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_q   <= '0;
            r_b_q   <= '0;
            r_cy_q  <= 1'b0;
            r_res_q <= '0;
            r_cnt_q <= '0;
            r_s_q   <= '0;
            r_c_q   <= 1'b0;
            r_v_q   <= 1'b0;
        end else begin
            r_a_q   <= w_a_d;
            r_b_q   <= w_b_d;
            r_cy_q  <= w_cy_d;
            r_res_q <= w_res_d;
            r_cnt_q <= w_cnt_d;
            r_s_q   <= w_s_d;
            r_c_q   <= w_c_d;
            r_v_q   <= w_v_d;
        end
    end

    assign o_s = r_s_q;
    assign o_c = r_c_q;
    assign o_v = r_v_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Directed self-checking bench for serial_adder (DIGIT=4 and
//               DIGIT=16 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start16;
    logic        sub;
    logic        x;
    logic [15:0] a;
    logic [15:0] b;

    logic        busy, done, c, v;
    logic [15:0] s;
    logic        busy16, done16, c16, v16;
    logic [15:0] s16;

    int errors = 0;
    int checks = 0;

    serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_sub(sub),
        .i_a(a), .i_b(b), .i_x(x),
        .o_busy(busy), .o_done(done), .o_s(s), .o_c(c), .o_v(v)
    );

    serial_adder #(.WIDTH(16), .DIGIT(16)) u_dut16 (
        .i_clk(clk), .i_rst(rst), .i_start(start16), .i_sub(sub),
        .i_a(a), .i_b(b), .i_x(x),
        .o_busy(busy16), .o_done(done16), .o_s(s16), .o_c(c16), .o_v(v16)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Launch one operation; lat = edges after accept until done (0 = timeout)
    task automatic do_op(input logic [15:0] ia, input logic [15:0] ib,
                         input logic isub, input logic ix,
                         output int lat, output int busy_cycles);
        a = ia; b = ib; sub = isub; x = ix; start = 1'b1;
        step;
        start = 1'b0;
        busy_cycles = busy ? 1 : 0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_cycles++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; start16 = 1'b1; sub = 1'b0; x = 1'b1;
        a = 16'($urandom); b = 16'($urandom);
        for (int i = 0; i < 2; i++) begin
            step;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
            checks++; if ({s, c, v} !== 18'h0) begin errors++; $display("FAIL reset_outs: got s=%h c=%b v=%b expected 0", s, c, v); end
            checks++; if ({busy16, done16, s16, c16, v16} !== 20'h0) begin errors++; $display("FAIL reset_outs16: got busy=%b done=%b s=%h expected 0", busy16, done16, s16); end
        end
        rst = 1'b0; start = 1'b0; start16 = 1'b0;
        step;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_release: got busy=%b done=%b expected 0 0", busy, done); end
    endtask

    task automatic test_add;
        int lat, bc;
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat, bc);
        checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d expected 4", lat); end
        checks++; if (bc !== 4) begin errors++; $display("FAIL add_busy_cycles: got %0d expected 4", bc); end
        checks++; if ({s, c, v} !== {16'h5555, 1'b0, 1'b0}) begin errors++; $display("FAIL add_result: got s=%h c=%b v=%b expected 5555 0 0", s, c, v); end
        step;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %b expected 0", done); end
        checks++; if (s !== 16'h5555) begin errors++; $display("FAIL add_hold: got %h expected 5555", s); end
    endtask

    task automatic test_carry;
        int lat, bc;
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bc);
        checks++; if ({s, c, v} !== {16'h0000, 1'b1, 1'b0}) begin errors++; $display("FAIL carry_wrap: got s=%h c=%b v=%b expected 0000 1 0 (lat %0d)", s, c, v, lat); end
        step;
        do_op(16'h7FFF, 16'h0000, 1'b0, 1'b1, lat, bc);
        checks++; if ({s, c, v} !== {16'h8000, 1'b0, 1'b1}) begin errors++; $display("FAIL carry_ovf: got s=%h c=%b v=%b expected 8000 0 1 (lat %0d)", s, c, v, lat); end
        step;
    endtask

    task automatic test_sub;
        int lat, bc;
        do_op(16'h0005, 16'h0007, 1'b1, 1'b0, lat, bc);
        checks++; if ({s, c, v} !== {16'hFFFE, 1'b0, 1'b0}) begin errors++; $display("FAIL sub_borrow: got s=%h c=%b v=%b expected fffe 0 0 (lat %0d)", s, c, v, lat); end
        step;
        do_op(16'h8000, 16'h0001, 1'b1, 1'b0, lat, bc);
        checks++; if ({s, c, v} !== {16'h7FFF, 1'b1, 1'b1}) begin errors++; $display("FAIL sub_ovf: got s=%h c=%b v=%b expected 7fff 1 1 (lat %0d)", s, c, v, lat); end
        step;
        do_op(16'h0100, 16'h0001, 1'b1, 1'b1, lat, bc);
        checks++; if ({s, c, v} !== {16'h00FE, 1'b1, 1'b0}) begin errors++; $display("FAIL sub_borrow_in: got s=%h c=%b v=%b expected 00fe 1 0 (lat %0d)", s, c, v, lat); end
        step;
    endtask

    task automatic test_hold_start;
        logic [15:0] prev_s;
        int          lat;
        prev_s = s;
        a = 16'h1111; b = 16'h2222; sub = 1'b0; x = 1'b0; start = 1'b1;
        step;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            checks++; if (s !== prev_s) begin errors++; $display("FAIL hold_s_in_run: got %h expected %h", s, prev_s); end
            a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); x = 1'($urandom);
            step;
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        checks++; if (lat !== 4) begin errors++; $display("FAIL hold_latency: got %0d expected 4", lat); end
        checks++; if ({s, c, v} !== {16'h3333, 1'b0, 1'b0}) begin errors++; $display("FAIL hold_result: got s=%h c=%b v=%b expected 3333 0 0", s, c, v); end
        step;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL hold_no_requeue: got busy=%b done=%b expected 0 0", busy, done); end
    endtask

    task automatic test_back_to_back;
        int lat, bc, gap;
        do_op(16'h0001, 16'h0002, 1'b0, 1'b0, lat, bc);
        checks++; if (s !== 16'h0003) begin errors++; $display("FAIL b2b_first: got %h expected 0003 (lat %0d)", s, lat); end
        a = 16'h0010; b = 16'h0020; sub = 1'b0; x = 1'b0; start = 1'b1;
        step;
        start = 1'b0;
        gap = 1;
        checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL b2b_accept: got busy=%b done=%b expected 1 0", busy, done); end
        checks++; if (s !== 16'h0003) begin errors++; $display("FAIL b2b_hold: got %h expected 0003", s); end
        for (int i = 0; i < 20; i++) begin
            step;
            gap++;
            if (done) break;
        end
        checks++; if (gap !== 5) begin errors++; $display("FAIL b2b_gap: got %0d expected 5", gap); end
        checks++; if (s !== 16'h0030) begin errors++; $display("FAIL b2b_second: got %h expected 0030", s); end
        step;
    endtask

    task automatic test_abort;
        int seen;
        a = 16'h00F0; b = 16'h000F; sub = 1'b0; x = 1'b0; start = 1'b1;
        step;
        start = 1'b0;
        step;
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort_state: got busy=%b done=%b expected 0 0", busy, done); end
        checks++; if ({s, c, v} !== 18'h0) begin errors++; $display("FAIL abort_outs: got s=%h c=%b v=%b expected 0", s, c, v); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step;
            if (done || busy) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen); end
    endtask

    task automatic test_digit16;
        a = 16'h00FF; b = 16'h0001; sub = 1'b0; x = 1'b0; start16 = 1'b1;
        step;
        start16 = 1'b0;
        checks++; if ({busy16, done16} !== 2'b10) begin errors++; $display("FAIL d16_run: got busy=%b done=%b expected 1 0", busy16, done16); end
        step;
        checks++; if (done16 !== 1'b1) begin errors++; $display("FAIL d16_done: got %b expected 1", done16); end
        checks++; if ({s16, c16, v16} !== {16'h0100, 1'b0, 1'b0}) begin errors++; $display("FAIL d16_result: got s=%h c=%b v=%b expected 0100 0 0", s16, c16, v16); end
        step;
        checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL d16_pulse: got %b expected 0", done16); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start16 = 1'b0; sub = 1'b0; x = 1'b0;
        a = '0; b = '0;
        test_reset;
        test_add;
        test_carry;
        test_sub;
        test_hold_start;
        test_back_to_back;
        test_abort;
        test_digit16;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder/subtractor: the sequential successor to the team's single-bit full-adder cell. It adds or subtracts two WIDTH-bit operands one DIGIT-bit slice per clock, rippling the carry between slices through a registered carry flop. It is used where a full-width ripple chain would not meet timing and latency is acceptable. It has a start/busy/done handshake and returns sum, carry-out and signed overflow.

## Interface
- WIDTH, 16, operand and result width in bits
- DIGIT, 4, bits processed per cycle; WIDTH % DIGIT must be 0, otherwise elaboration fails; N = WIDTH/DIGIT
- i_clk  input  1  clock; all state changes on the rising edge
- i_rst  input  1  reset; one clock, synchronous, active-high
- i_start  input  1  request; sampled only when not in RUN
- i_sub  input  1  0 = add, 1 = subtract; latched on an accepted start
- i_a  input  WIDTH  operand A; latched on an accepted start
- i_b  input  WIDTH  operand B; latched on an accepted start
- i_x  input  1  carry-in (add) or borrow-in (sub); latched on an accepted start
- o_busy  output  1  high during RUN
- o_done  output  1  one-cycle pulse when a new result is presented
- o_s  output  WIDTH  result
- o_c  output  1  carry-out of the MSB (in sub mode, 1 = no borrow)
- o_v  output  1  signed two's-complement overflow

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: waits for a start.
  - RUN: lasts exactly N cycles.
  - DONE: lasts exactly 1 cycle, then returns to IDLE.
- Start acceptance: i_start is accepted in IDLE or DONE and moves the block to RUN. It is ignored in RUN, with no queueing.
- On acceptance, the block latches:
  - A = i_a;
  - B = i_sub ? ~i_b : i_b;
  - carry register = i_sub ? ~i_x : i_x.
- Subtract therefore computes A - B - i_x.
- RUN cycle k (k = 0..N-1):
  - digit k = bits [k*DIGIT +: DIGIT], LSB slice first, is summed as A_k + B_k + carry;
  - the sum digit is written into an internal result shift register;
  - the carry register takes the slice carry-out.
- Final slice (k = N-1): also captures the carry into bit WIDTH-1 and the carry out of bit WIDTH-1.
  - o_c = carry out of bit WIDTH-1.
  - o_v = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Output update: o_s, o_c and o_v load from the internal registers on the RUN→DONE transition. They hold their previous values throughout RUN, and hold the new values until the next result is loaded.
- Arithmetic is modulo 2^WIDTH; there is no saturation.
- DIGIT == WIDTH is legal: N = 1, one RUN cycle.

## Timing
- Reset values: state IDLE; o_s = 0, o_c = 0, o_v = 0, o_busy = 0, o_done = 0; internal operand, carry and shift registers = 0.
- Reset mid-operation: reset asserted in any state aborts it. The block is in IDLE with all outputs at their reset values in the cycle after. No o_done is produced for the aborted operation.
- Reset and i_start in the same cycle: reset wins and the start is dropped.
- Latency: start accepted at edge t (state RUN from t). Then:
  - o_busy is high for cycles t..t+N-1;
  - at edge t+N the state becomes DONE, o_done = 1 and the new o_s/o_c/o_v are visible;
  - at edge t+N+1, o_done = 0.
- Back-to-back: i_start high during DONE is accepted. o_busy rises in the next cycle and the DONE outputs remain until the following DONE. Sustained throughput is one result per N+1 cycles.
- Input changes on i_a, i_b, i_sub and i_x after acceptance have no effect on the running operation.

## Test plan
- Reset: assert i_rst for 2 cycles with random inputs and i_start = 1 → all outputs 0, o_busy stays 0, no o_done.
- Add (WIDTH=16, DIGIT=4): i_a = 0x1234, i_b = 0x4321, i_x = 0, start at edge 0 → o_busy high for 4 cycles, o_done at edge 4 only, o_s = 0x5555, o_c = 0, o_v = 0.
- Carry and overflow:
  - 0xFFFF + 0x0001, i_x = 0 → o_s = 0x0000, o_c = 1, o_v = 0.
  - 0x7FFF + 0x0000, i_x = 1 → o_s = 0x8000, o_c = 0, o_v = 1.
- Subtract:
  - i_sub = 1, 0x0005 - 0x0007, i_x = 0 → o_s = 0xFFFE, o_c = 0, o_v = 0.
  - 0x8000 - 0x0001 → o_s = 0x7FFF, o_c = 1, o_v = 1.
- Handshake:
  - i_start held high through RUN with changing operands → only the first operation executes and the DONE outputs match the first operands.
  - Start in the DONE cycle → second o_done exactly 5 cycles after the first.
  - o_s is unchanged during RUN.
- Abort and degenerate case:
  - i_rst at RUN cycle 2 → IDLE with outputs 0 next cycle, no o_done.
  - Rebuild with DIGIT = 16: 0x00FF + 0x0001 → o_done at edge 1, o_s = 0x0100.
